// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb -- write-port arbiter for the 32x32 general-purpose register file.
//
// Two writers share the single register-file write port:
//   * pipeline writeback (priority, no handshake, held off with stall_pipe)
//   * multiply/divide unit result (valid/ready handshake)
// A starvation counter lets the pipeline win at most STARVE_LIMIT consecutive
// cycles against a waiting MDU result; the next cycle is a forced pipeline
// bubble in which the MDU result drains. A scoreboard tracks destinations of
// in-flight MDU operations and flags read hazards to issue logic.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   pipe_wr_en/addr/data             pipeline writeback request
//   stall_pipe                       pipeline must hold its writeback
//   mdu_valid/addr/data, mdu_ready   MDU result handshake
//   mdu_issue, mdu_issue_addr        MDU operation issued (sets pending bit)
//   rd_addr1/2, hazard1/2            read-port hazard lookup
//   regwrite, write_addr, data_in    registered register-file write port
//   stat_pipe_wr/mdu_wr/force        saturating statistics (GPR_WB_ARB_STATS_EN)
//
// Optional feature macro: GPR_WB_ARB_STATS_EN adds the statistics counters.
module gpr_wb_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wr_en,
  input  logic [4:0]  pipe_wr_addr,
  input  logic [31:0] pipe_wr_data,
  output logic        stall_pipe,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_addr,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        hazard1,
  output logic        hazard2,
`ifdef GPR_WB_ARB_STATS_EN
  output logic [CNT_W-1:0] stat_pipe_wr,
  output logic [CNT_W-1:0] stat_mdu_wr,
  output logic [CNT_W-1:0] stat_force,
`endif
  output logic        regwrite,
  output logic [4:0]  write_addr,
  output logic [31:0] data_in
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Elaboration-time range check of the configuration.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || CNT_W < 1) begin : g_bad_param
    $error("gpr_wb_arb: STARVE_LIMIT must be 1..15 and CNT_W >= 1");
  end

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        grant_pipe_s, grant_mdu_s;
  logic [31:0] pend_r, pend_s;
  logic [31:0] set_s, clr_s;

  // Arbitration decision and next state / starvation count.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    grant_pipe_s = 1'b0;
    grant_mdu_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (mdu_valid && pipe_wr_en) begin
          grant_pipe_s = 1'b1;
          cnt_s        = 4'd1;
          if (LIMIT <= 4'd1) begin
            state_s = FORCE;
          end else begin
            state_s = WAIT;
          end
        end else if (mdu_valid) begin
          grant_mdu_s = 1'b1;
        end else begin
          grant_pipe_s = pipe_wr_en;
        end
      end
      WAIT: begin
        if (!mdu_valid) begin
          // MDU withdrew its result: nothing is starving any more.
          grant_pipe_s = pipe_wr_en;
          cnt_s        = 4'd0;
          state_s      = IDLE;
        end else if (!pipe_wr_en) begin
          grant_mdu_s = 1'b1;
          cnt_s       = 4'd0;
          state_s     = IDLE;
        end else begin
          grant_pipe_s = 1'b1;
          cnt_s        = cnt_r + 4'd1;
          if ((cnt_r + 4'd1) >= LIMIT) begin
            state_s = FORCE;
          end else begin
            state_s = WAIT;
          end
        end
      end
      FORCE: begin
        // Pipeline is stalled; the waiting MDU result takes the port.
        grant_mdu_s = mdu_valid;
        cnt_s       = 4'd0;
        state_s     = IDLE;
      end
      default: begin
        cnt_s   = 4'd0;
        state_s = IDLE;
      end
    endcase
  end

  // Handshake is gated by reset so no grant is signalled while held in reset.
  assign mdu_ready  = grant_mdu_s & rst_n;
  assign stall_pipe = (state_r == FORCE);

  // Scoreboard update: issue sets, MDU grant clears, set wins; r0 never pends.
  always_comb begin
    set_s = 32'd0;
    clr_s = 32'd0;
    if (mdu_issue) begin
      set_s = 32'd1 << mdu_issue_addr;
    end else begin
      set_s = 32'd0;
    end
    if (grant_mdu_s) begin
      clr_s = 32'd1 << mdu_addr;
    end else begin
      clr_s = 32'd0;
    end
    pend_s = ((pend_r & ~clr_s) | set_s) & ~32'd1;
  end

  assign hazard1 = pend_r[rd_addr1];
  assign hazard2 = pend_r[rd_addr2];

  // Arbiter FSM, scoreboard and registered register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      pend_r     <= 32'd0;
      regwrite   <= 1'b0;
      write_addr <= 5'd0;
      data_in    <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pend_r  <= pend_s;
      if (grant_mdu_s) begin
        regwrite   <= (mdu_addr != 5'd0);
        write_addr <= mdu_addr;
        data_in    <= mdu_data;
      end else if (grant_pipe_s) begin
        regwrite   <= (pipe_wr_addr != 5'd0);
        write_addr <= pipe_wr_addr;
        data_in    <= pipe_wr_data;
      end else begin
        regwrite <= 1'b0;
      end
    end
  end

`ifdef GPR_WB_ARB_STATS_EN
  // Saturating grant / forced-bubble statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pipe_wr <= {CNT_W{1'b0}};
      stat_mdu_wr  <= {CNT_W{1'b0}};
      stat_force   <= {CNT_W{1'b0}};
    end else begin
      if (grant_pipe_s && (stat_pipe_wr != {CNT_W{1'b1}})) begin
        stat_pipe_wr <= stat_pipe_wr + CNT_W'(1);
      end else begin
        stat_pipe_wr <= stat_pipe_wr;
      end
      if (grant_mdu_s && (stat_mdu_wr != {CNT_W{1'b1}})) begin
        stat_mdu_wr <= stat_mdu_wr + CNT_W'(1);
      end else begin
        stat_mdu_wr <= stat_mdu_wr;
      end
      if ((state_r == FORCE) && (stat_force != {CNT_W{1'b1}})) begin
        stat_force <= stat_force + CNT_W'(1);
      end else begin
        stat_force <= stat_force;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_gpr_wb_arb.sv
module tb_gpr_wb_arb;

  localparam int LIMIT = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_wr_en = 1'b0;
  logic [4:0]  pipe_wr_addr = 5'd0;
  logic [31:0] pipe_wr_data = 32'd0;
  logic        stall_pipe;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_addr = 5'd0;
  logic [31:0] mdu_data = 32'd0;
  logic        mdu_ready;
  logic        mdu_issue = 1'b0;
  logic [4:0]  mdu_issue_addr = 5'd0;
  logic [4:0]  rd_addr1 = 5'd0;
  logic [4:0]  rd_addr2 = 5'd0;
  logic        hazard1, hazard2;
  logic        regwrite;
  logic [4:0]  write_addr;
  logic [31:0] data_in;
`ifdef GPR_WB_ARB_STATS_EN
  logic [CNT_W-1:0] stat_pipe_wr, stat_mdu_wr, stat_force;
`endif

  gpr_wb_arb #(.STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wr_en(pipe_wr_en), .pipe_wr_addr(pipe_wr_addr), .pipe_wr_data(pipe_wr_data),
    .stall_pipe(stall_pipe),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .hazard1(hazard1), .hazard2(hazard2),
`ifdef GPR_WB_ARB_STATS_EN
    .stat_pipe_wr(stat_pipe_wr), .stat_mdu_wr(stat_mdu_wr), .stat_force(stat_force),
`endif
    .regwrite(regwrite), .write_addr(write_addr), .data_in(data_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: pending set, starvation streak, expected write port.
  logic [31:0] pend_m;
  int          streak_m, n_streak;
  bit          force_m, n_force;
  bit          g_pipe_m, g_mdu_m, exp_stall;
  logic        exp_rw;
  logic [4:0]  exp_wa;
  logic [31:0] exp_wd;

  task automatic model_reset();
    pend_m = 32'd0; streak_m = 0; force_m = 1'b0;
    exp_rw = 1'b0; exp_wa = 5'd0; exp_wd = 32'd0;
  endtask

  // Decide who owns the write port this cycle from the arbitration rules.
  task automatic model_comb();
    exp_stall = force_m; g_pipe_m = 1'b0; g_mdu_m = 1'b0; n_streak = 0; n_force = 1'b0;
    if (force_m) begin
      g_mdu_m = mdu_valid;
    end else if (mdu_valid && !pipe_wr_en) begin
      g_mdu_m = 1'b1;
    end else if (mdu_valid) begin
      g_pipe_m = 1'b1;
      n_streak = streak_m + 1;
      n_force  = (n_streak >= LIMIT);
    end else begin
      g_pipe_m = pipe_wr_en;
    end
  endtask

  task automatic drive(input bit pe, input logic [4:0] pa, input logic [31:0] pd,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input bit iv, input logic [4:0] ia,
                       input logic [4:0] r1, input logic [4:0] r2);
    pipe_wr_en = pe; pipe_wr_addr = pa; pipe_wr_data = pd;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    mdu_issue = iv; mdu_issue_addr = ia;
    rd_addr1 = r1; rd_addr2 = r2;
    model_comb();
    @(negedge clk);
  endtask

  task automatic tick();
    if (g_mdu_m) begin
      exp_rw = (mdu_addr != 5'd0); exp_wa = mdu_addr; exp_wd = mdu_data;
      pend_m[mdu_addr] = 1'b0;
    end else if (g_pipe_m) begin
      exp_rw = (pipe_wr_addr != 5'd0); exp_wa = pipe_wr_addr; exp_wd = pipe_wr_data;
    end else begin
      exp_rw = 1'b0;
    end
    if (mdu_issue && mdu_issue_addr != 5'd0) pend_m[mdu_issue_addr] = 1'b1;
    streak_m = n_streak; force_m = n_force;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 5'd4, 32'h55, 1, 5'd6, 32'h66, 1, 5'd6, 5'd6, 5'd4);
    checks++; if (mdu_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", mdu_ready); end
    checks++; if (stall_pipe !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall_pipe); end
    checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin fails++; $display("FAIL reset_hazard got=%b%b exp=00", hazard1, hazard2); end
    checks++; if (regwrite !== 1'b0 || write_addr !== 5'd0 || data_in !== 32'd0) begin
      fails++; $display("FAIL reset_wport got=%b/%0d/%h exp=0/0/0", regwrite, write_addr, data_in); end
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    idle_cycle();
    checks++; if (hazard1 !== 1'b0 || regwrite !== 1'b0) begin fails++; $display("FAIL reset_release got=%b/%b exp=0/0", hazard1, regwrite); end
  endtask

  task automatic test_pipe_write();
    drive(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    checks++; if (mdu_ready !== 1'b0 || stall_pipe !== 1'b0) begin fails++; $display("FAIL pipe_handshake got=%b/%b exp=0/0", mdu_ready, stall_pipe); end
    tick();
    checks++; if (regwrite !== 1'b1 || write_addr !== 5'd5 || data_in !== 32'h1234) begin
      fails++; $display("FAIL pipe_write got=%b/%0d/%h exp=1/5/1234", regwrite, write_addr, data_in); end
    idle_cycle();
    checks++; if (regwrite !== 1'b0 || write_addr !== 5'd5 || data_in !== 32'h1234) begin
      fails++; $display("FAIL pipe_hold got=%b/%0d/%h exp=0/5/1234", regwrite, write_addr, data_in); end
  endtask

  task automatic test_mdu_write();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, 5'd9, 5'd0);
    tick();
    drive(0, 5'd0, 32'd0, 1, 5'd9, 32'hCAFE, 0, 5'd0, 5'd9, 5'd0);
    checks++; if (hazard1 !== 1'b1) begin fails++; $display("FAIL mdu_pending got=%b exp=1", hazard1); end
    checks++; if (mdu_ready !== 1'b1) begin fails++; $display("FAIL mdu_ready got=%b exp=1", mdu_ready); end
    tick();
    checks++; if (regwrite !== 1'b1 || write_addr !== 5'd9 || data_in !== 32'hCAFE) begin
      fails++; $display("FAIL mdu_write got=%b/%0d/%h exp=1/9/cafe", regwrite, write_addr, data_in); end
    checks++; if (hazard1 !== 1'b0) begin fails++; $display("FAIL mdu_clear got=%b exp=0", hazard1); end
  endtask

  task automatic test_starve();
    idle_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'd10, 32'h100 + i, 1, 5'd3, 32'hD00D, 0, 5'd0, 5'd0, 5'd0);
      checks++; if (stall_pipe !== (i == 4) || mdu_ready !== (i == 4)) begin
        fails++; $display("FAIL starve_cyc%0d got stall=%b ready=%b exp=%b", i, stall_pipe, mdu_ready, (i == 4)); end
      checks++; if (stall_pipe !== exp_stall || mdu_ready !== g_mdu_m) begin
        fails++; $display("FAIL starve_model%0d got=%b/%b exp=%b/%b", i, stall_pipe, mdu_ready, exp_stall, g_mdu_m); end
      tick();
      if (i < 4) begin
        checks++; if (regwrite !== 1'b1 || write_addr !== 5'd10 || data_in !== 32'h100 + i) begin
          fails++; $display("FAIL starve_pipe%0d got=%b/%0d/%h", i, regwrite, write_addr, data_in); end
      end
    end
    checks++; if (regwrite !== 1'b1 || write_addr !== 5'd3 || data_in !== 32'hD00D) begin
      fails++; $display("FAIL starve_drain got=%b/%0d/%h exp=1/3/d00d", regwrite, write_addr, data_in); end
    drive(1, 5'd11, 32'h77, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    checks++; if (stall_pipe !== 1'b0) begin fails++; $display("FAIL starve_after got=%b exp=0", stall_pipe); end
    tick();
  endtask

  task automatic test_hazard();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd7);
    checks++; if (hazard1 !== 1'b0) begin fails++; $display("FAIL haz_early got=%b exp=0", hazard1); end
    tick();
    drive(1, 5'd7, 32'hAA, 1, 5'd7, 32'hBB, 0, 5'd0, 5'd7, 5'd7);
    checks++; if (hazard1 !== 1'b1 || hazard2 !== 1'b1) begin fails++; $display("FAIL haz_set got=%b%b exp=11", hazard1, hazard2); end
    tick();
    // Grant for r7 and a new issue to r7 in the same cycle: set wins.
    drive(0, 5'd0, 32'd0, 1, 5'd7, 32'hBB, 1, 5'd7, 5'd7, 5'd1);
    checks++; if (mdu_ready !== 1'b1 || hazard1 !== 1'b1) begin fails++; $display("FAIL haz_grant got=%b/%b exp=1/1", mdu_ready, hazard1); end
    tick();
    checks++; if (regwrite !== 1'b1 || data_in !== 32'hBB) begin fails++; $display("FAIL haz_late_win got=%b/%h exp=1/bb", regwrite, data_in); end
    drive(0, 5'd0, 32'd0, 1, 5'd7, 32'hCC, 0, 5'd0, 5'd7, 5'd0);
    checks++; if (hazard1 !== 1'b1) begin fails++; $display("FAIL haz_set_wins got=%b exp=1", hazard1); end
    tick();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd7, 5'd7);
    checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin fails++; $display("FAIL haz_cleared got=%b%b exp=00", hazard1, hazard2); end
    tick();
  endtask

  task automatic test_addr0();
    drive(1, 5'd0, 32'hDEAD, 0, 5'd0, 32'd0, 1, 5'd0, 5'd0, 5'd0);
    tick();
    checks++; if (regwrite !== 1'b0) begin fails++; $display("FAIL addr0_pipe got=%b exp=0", regwrite); end
    drive(0, 5'd0, 32'd0, 1, 5'd0, 32'hBEEF, 0, 5'd0, 5'd0, 5'd0);
    checks++; if (hazard1 !== 1'b0 || mdu_ready !== 1'b1) begin fails++; $display("FAIL addr0_haz got=%b/%b exp=0/1", hazard1, mdu_ready); end
    tick();
    checks++; if (regwrite !== 1'b0) begin fails++; $display("FAIL addr0_mdu got=%b exp=0", regwrite); end
  endtask

  task automatic test_random();
    bit cur_v = 1'b0;
    bit acc = 1'b1;
    logic [4:0]  cur_a = 5'd0;
    logic [31:0] cur_d = 32'd0;
    for (int n = 0; n < 400; n++) begin
      if (!cur_v || acc) begin
        cur_v = ($urandom_range(2, 0) != 0);
        cur_a = 5'($urandom); cur_d = $urandom;
      end else if ($urandom_range(19, 0) == 0) begin
        cur_v = 1'b0;
      end
      drive($urandom_range(3, 0) != 0, 5'($urandom), $urandom, cur_v, cur_a, cur_d,
            $urandom_range(2, 0) == 0, 5'($urandom), 5'($urandom), 5'($urandom));
      acc = g_mdu_m;
      checks++; if (stall_pipe !== exp_stall || mdu_ready !== g_mdu_m) begin
        fails++; $display("FAIL rnd_arb%0d got=%b/%b exp=%b/%b", n, stall_pipe, mdu_ready, exp_stall, g_mdu_m); end
      checks++; if (hazard1 !== pend_m[rd_addr1] || hazard2 !== pend_m[rd_addr2]) begin
        fails++; $display("FAIL rnd_haz%0d got=%b%b exp=%b%b", n, hazard1, hazard2, pend_m[rd_addr1], pend_m[rd_addr2]); end
      tick();
      checks++; if (regwrite !== exp_rw || write_addr !== exp_wa || data_in !== exp_wd) begin
        fails++; $display("FAIL rnd_wport%0d got=%b/%0d/%h exp=%b/%0d/%h", n, regwrite, write_addr, data_in, exp_rw, exp_wa, exp_wd); end
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd12, 5'd12, 5'd0);
    tick();
    drive(1, 5'd13, 32'h9, 1, 5'd12, 32'h8, 1, 5'd14, 5'd12, 5'd14);
    tick();
    drive(1, 5'd13, 32'h9, 1, 5'd12, 32'h8, 0, 5'd0, 5'd12, 5'd14);
    rst_n = 1'b0;
    #1;
    checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0 || mdu_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_comb got=%b%b/%b exp=00/0", hazard1, hazard2, mdu_ready); end
    checks++; if (regwrite !== 1'b0 || write_addr !== 5'd0 || data_in !== 32'd0) begin
      fails++; $display("FAIL rstmid_wport got=%b/%0d/%h exp=0/0/0", regwrite, write_addr, data_in); end
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    drive(1, 5'd13, 32'h9, 1, 5'd12, 32'h8, 0, 5'd0, 5'd12, 5'd14);
    checks++; if (stall_pipe !== 1'b0 || mdu_ready !== 1'b0 || hazard1 !== 1'b0) begin
      fails++; $display("FAIL rstmid_after got=%b/%b/%b exp=0/0/0", stall_pipe, mdu_ready, hazard1); end
    tick();
    idle_cycle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pipe_write();
    test_mdu_write();
    test_starve();
    test_hazard();
    test_addr0();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arb.md
Name: gpr_wb_arb

Overview:
- Shares the single write port of the 32x32 general-purpose register file between two writers: pipeline writeback (priority) and the long-latency multiply/divide unit (MDU).
- Tracks destination registers of in-flight MDU operations in a scoreboard and flags read hazards to issue logic.
- A starvation counter forces a pipeline writeback bubble so MDU results always drain.
- Sits between the writeback stage, the MDU and the register file write port.

Parameters:
STARVE_LIMIT, 4, consecutive cycles an MDU result may wait before a forced pipeline stall (1..15)
CNT_W, 16, width of statistics counters (optional feature only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pipe_wr_en  in  1  pipeline writeback request (no handshake; accepted unless stall_pipe=1)
pipe_wr_addr  in  5  pipeline destination register
pipe_wr_data  in  32  pipeline writeback data
stall_pipe  out  1  pipeline must hold its writeback this cycle
mdu_valid  in  1  MDU result valid
mdu_addr  in  5  MDU destination register
mdu_data  in  32  MDU result data
mdu_ready  out  1  MDU result accepted this cycle (valid&ready)
mdu_issue  in  1  MDU operation issued this cycle
mdu_issue_addr  in  5  destination of issued MDU operation
rd_addr1  in  5  read address, port 1
rd_addr2  in  5  read address, port 2
hazard1  out  1  rd_addr1 has a pending MDU write
hazard2  out  1  rd_addr2 has a pending MDU write
regwrite  out  1  register file write enable (registered)
write_addr  out  5  register file write address (registered)
data_in  out  32  register file write data (registered)

Behaviour:
- Reset (async, rst_n=0): regwrite=0, write_addr=0, data_in=0, scoreboard all clear, wait counter=0, FSM=IDLE; stall_pipe=0, mdu_ready=0, hazard1/2=0.
- FSM states: IDLE, WAIT, FORCE.
- IDLE: if mdu_valid && !pipe_wr_en, grant MDU (mdu_ready=1), stay IDLE. If mdu_valid && pipe_wr_en, grant pipe, counter=1, go WAIT.
- WAIT: free cycle (pipe_wr_en=0) grants MDU, counter=0, go IDLE. Otherwise grant pipe, counter+1. Go FORCE when counter reaches STARVE_LIMIT. mdu_valid must stay high with stable addr/data until mdu_ready (MDU protocol).
- FORCE: stall_pipe=1 combinationally; pipe_wr_en ignored; grant MDU; counter=0; go IDLE.
- Write port is registered, so the write lands one cycle after grant. The granted source's addr/data drive write_addr/data_in next cycle, with regwrite=1. No grant gives regwrite=0; write_addr/data_in hold.
- Address 0: grant and handshake proceed normally, but regwrite stays 0 (r0 never written).
- Scoreboard (32 bits, bit 0 tied 0):
  - mdu_issue with addr!=0 sets pend[mdu_issue_addr].
  - MDU grant clears pend[mdu_addr].
  - Same-cycle set and clear of the same address: set wins.
- hazard1=pend[rd_addr1], hazard2=pend[rd_addr2]; combinational from the registered scoreboard.
- Pipeline writeback to a pending address is legal; the later grant wins in the register file.
- mdu_valid deasserted in WAIT (protocol violation): return to IDLE, counter=0.
- Reset mid-operation discards pending grants and scoreboard.

Optional Feature:
GPR_WB_ARB_STATS_EN:
- Defined: adds outputs stat_pipe_wr, stat_mdu_wr and stat_force, each CNT_W bits. They count pipe grants, MDU grants and FORCE cycles. Saturating, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then pipe_wr_en=1 addr=5 data=0x1234 -> next cycle regwrite=1 write_addr=5 data_in=0x1234; mdu_ready=0.
- mdu_valid addr=9 data=0xCAFE with pipe idle -> mdu_ready=1 same cycle; next cycle write r9=0xCAFE; pend[9] clears.
- STARVE_LIMIT=4, pipe_wr_en held 1, mdu_valid held addr=3 -> 4 pipe grants, then stall_pipe=1 for 1 cycle and MDU grant; r3 written next cycle.
- mdu_issue addr=7, rd_addr1=7 -> hazard1=1 next cycle until MDU grant for r7; hazard1=0 the cycle after grant.
- Same cycle: MDU grant addr=7 and mdu_issue addr=7 -> pend[7] remains 1.
- Pipe write to addr=0 -> regwrite stays 0; mdu_issue addr=0 -> no hazard ever.
